// File: rtl/mnist_ctrl_mac_core_if.sv
// Control and data bundle between the MNIST sequencer/MAC core and its
// surroundings (memories, image buffer, layer-2 datapath).
interface mnist_ctrl_mac_core_if #(
  parameter int HID_SIZE = 32,
  parameter int OUT_SIZE = 10,
  parameter int ACC_W    = 20
);
  logic                      start;
  logic                      done;
  logic                      busy;
  logic [1:0]                layer_sel;
  logic [9:0]                row_idx;
  logic [9:0]                cycle_cnt;
  logic                      load_img;
  logic                      comp_l1;
  logic                      apply_relu;
  logic                      comp_l2;
  logic                      find_max;
  logic                      mac_en_l1;
  logic                      mac_clr_l1;
  logic                      mac_en_l2;
  logic                      mac_clr_l2;
  logic                      l1_init_bias;
  logic [7:0]                pixel;
  logic [8*HID_SIZE-1:0]     w1_packed;
  logic [8*HID_SIZE-1:0]     b1_packed;
  logic [ACC_W*HID_SIZE-1:0] l1_acc_packed;
  logic [ACC_W*OUT_SIZE-1:0] scores_packed;
  logic [3:0]                max_idx;

  modport master (
    output start, l1_init_bias, pixel,
    output w1_packed, b1_packed, scores_packed,
    input  done, busy, layer_sel, row_idx, cycle_cnt,
    input  load_img, comp_l1, apply_relu, comp_l2, find_max,
    input  mac_en_l1, mac_clr_l1, mac_en_l2, mac_clr_l2,
    input  l1_acc_packed, max_idx
  );

  modport slave (
    input  start, l1_init_bias, pixel,
    input  w1_packed, b1_packed, scores_packed,
    output done, busy, layer_sel, row_idx, cycle_cnt,
    output load_img, comp_l1, apply_relu, comp_l2, find_max,
    output mac_en_l1, mac_clr_l1, mac_en_l2, mac_clr_l2,
    output l1_acc_packed, max_idx
  );
endinterface

// File: rtl/mnist_ctrl_mac_core.sv
// MNIST 784-32-10 core: inference sequencer, 32-lane layer-1 MAC array
// and combinational 10-way argmax.
module mnist_ctrl_mac_core #(
  parameter int IMG_SIZE = 784,
  parameter int HID_SIZE = 32,
  parameter int OUT_SIZE = 10,
  parameter int ACC_W    = 20
) (
  input logic                 clk,
  input logic                 rst,
  mnist_ctrl_mac_core_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD, L1, RELU, L2, MAX, DONE
  } state_t;

  state_t state;
  state_t nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (bus.start) nxt = LOAD;
      LOAD: nxt = L1;
      L1: begin
        if (bus.row_idx == 10'(IMG_SIZE - 1))
          nxt = RELU;
      end
      RELU: if (bus.cycle_cnt == 10'd1) nxt = L2;
      L2: begin
        if (bus.row_idx == 10'(HID_SIZE - 1))
          nxt = MAX;
      end
      MAX:  nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the state being entered so they
  // line up with the registered state every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.done       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.layer_sel  <= 2'd0;
      bus.row_idx    <= '0;
      bus.cycle_cnt  <= '0;
      bus.load_img   <= 1'b0;
      bus.comp_l1    <= 1'b0;
      bus.apply_relu <= 1'b0;
      bus.comp_l2    <= 1'b0;
      bus.find_max   <= 1'b0;
      bus.mac_en_l1  <= 1'b0;
      bus.mac_clr_l1 <= 1'b0;
      bus.mac_en_l2  <= 1'b0;
      bus.mac_clr_l2 <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state)
        bus.cycle_cnt <= '0;
      else if (!(&bus.cycle_cnt))
        bus.cycle_cnt <= bus.cycle_cnt + 10'd1;
      if (nxt == state && (state == L1 || state == L2))
        bus.row_idx <= bus.row_idx + 10'd1;
      else
        bus.row_idx <= '0;
      if (state == IDLE && bus.start)
        bus.done <= 1'b0;
      else if (state == DONE)
        bus.done <= 1'b1;
      bus.busy       <= (nxt != IDLE);
      bus.layer_sel  <= (nxt == L1)  ? 2'd1 :
                        (nxt == L2)  ? 2'd2 :
                        (nxt == MAX) ? 2'd3 : 2'd0;
      bus.load_img   <= (nxt == LOAD);
      bus.comp_l1    <= (nxt == L1);
      bus.apply_relu <= (nxt == RELU);
      bus.comp_l2    <= (nxt == L2);
      bus.find_max   <= (nxt == MAX);
      bus.mac_en_l1  <= (nxt == L1);
      bus.mac_clr_l1 <= (nxt == LOAD);
      bus.mac_en_l2  <= (nxt == L2);
      bus.mac_clr_l2 <= (nxt == LOAD);
    end
  end

  for (genvar k = 0; k < HID_SIZE; k++) begin : g_lane
    logic signed [7:0]       w;
    logic signed [7:0]       b;
    logic signed [15:0]      p;
    logic signed [ACC_W-1:0] pe;
    logic signed [ACC_W-1:0] be;
    logic signed [ACC_W-1:0] acc;

    assign w  = bus.w1_packed[8*k +: 8];
    assign b  = bus.b1_packed[8*k +: 8];
    assign p  = $signed(bus.pixel) * w;
    assign pe = ACC_W'(p);
    assign be = ACC_W'(b);

    always_ff @(posedge clk) begin
      if (rst || bus.mac_clr_l1)
        acc <= '0;
      else if (bus.l1_init_bias)
        acc <= be + (bus.mac_en_l1 ? pe : '0);
      else if (bus.mac_en_l1)
        acc <= acc + pe;
    end

    assign bus.l1_acc_packed[ACC_W*k +: ACC_W] = acc;
  end

  logic signed [ACC_W-1:0] best_val;
  logic [3:0]              best_idx;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_idx = 4'd0;
    best_val = $signed(bus.scores_packed[ACC_W-1:0]);
    for (int j = 1; j < OUT_SIZE; j++) begin
      if ($signed(bus.scores_packed[ACC_W*j +: ACC_W]) > best_val) begin
        best_val = $signed(bus.scores_packed[ACC_W*j +: ACC_W]);
        best_idx = 4'(j);
      end
    end
  end

  assign bus.max_idx = best_idx;

endmodule

// File: tb/tb_mnist_ctrl_mac_core.sv
// Scoreboard bench for mnist_ctrl_mac_core: schedule-based reference
// model, randomized data, decoupled negedge monitor.
module tb_mnist_ctrl_mac_core;

  typedef struct {
    logic [12:0]  ctl;
    logic [9:0]   row;
    logic [9:0]   cyc;
    logic [639:0] acc;
    logic [3:0]   mx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic init;
  byte  pixel;
  byte  w [32];
  byte  b [32];
  logic signed [19:0] sc [10];

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  int  m_t    = -1;
  bit  m_done = 1'b0;
  int  m_idle = 0;
  logic signed [19:0] macc [32];

  mnist_ctrl_mac_core_if bus();

  mnist_ctrl_mac_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.start         = start;
    bus.l1_init_bias  = init;
    bus.pixel         = pixel;
    bus.w1_packed     = '0;
    bus.b1_packed     = '0;
    bus.scores_packed = '0;
    for (int k = 0; k < 32; k++) begin
      bus.w1_packed[8*k +: 8] = w[k];
      bus.b1_packed[8*k +: 8] = b[k];
    end
    for (int j = 0; j < 10; j++)
      bus.scores_packed[20*j +: 20] = sc[j];
  end

  // Phase schedule after an accepted start: t=0 load, 1..784 layer 1,
  // 785..786 relu, 787..818 layer 2, 819 argmax, 820 done.
  function automatic exp_t model_out();
    exp_t e;
    bit ld, l1, rl, l2, mx;
    logic [1:0] ls;
    ld = (m_t == 0);
    l1 = (m_t >= 1 && m_t <= 784);
    rl = (m_t == 785 || m_t == 786);
    l2 = (m_t >= 787 && m_t <= 818);
    mx = (m_t == 819);
    ls = l1 ? 2'd1 : l2 ? 2'd2 : mx ? 2'd3 : 2'd0;
    e.ctl = {m_t >= 0, m_done, ls, ld, l1, rl, l2, mx,
             l1, ld, l2, ld};
    e.row = l1 ? 10'(m_t - 1) : l2 ? 10'(m_t - 787) : 10'd0;
    if (m_t < 0)  e.cyc = 10'(m_idle);
    else if (l1)  e.cyc = 10'(m_t - 1);
    else if (rl)  e.cyc = 10'(m_t - 785);
    else if (l2)  e.cyc = 10'(m_t - 787);
    else          e.cyc = 10'd0;
    for (int k = 0; k < 32; k++)
      e.acc[20*k +: 20] = macc[k];
    e.mx = 4'd0;
    return e;
  endfunction

  function automatic logic [3:0] amax();
    logic signed [19:0] m;
    m = sc[0];
    for (int j = 1; j < 10; j++)
      if (sc[j] > m) m = sc[j];
    for (int j = 0; j < 10; j++)
      if (sc[j] == m) return 4'(j);
    return 4'd0;
  endfunction

  function automatic void model_edge();
    bit clr, en;
    int p;
    if (rst) begin
      m_t = -1;
      m_done = 1'b0;
      m_idle = 0;
      for (int k = 0; k < 32; k++) macc[k] = '0;
      return;
    end
    clr = (m_t == 0);
    en  = (m_t >= 1 && m_t <= 784);
    for (int k = 0; k < 32; k++) begin
      p = int'(pixel) * int'(w[k]);
      if (clr)       macc[k] = '0;
      else if (init) macc[k] = 20'(int'(b[k]) + (en ? p : 0));
      else if (en)   macc[k] = macc[k] + 20'(p);
    end
    if (m_t < 0) begin
      if (start) begin
        m_t = 0;
        m_done = 1'b0;
      end else if (m_idle < 1023) begin
        m_idle++;
      end
    end else begin
      m_t++;
      if (m_t == 821) begin
        m_t = -1;
        m_done = 1'b1;
        m_idle = 0;
      end
    end
  endfunction

  task automatic step();
    exp_t e;
    e = model_out();
    e.mx = amax();
    q.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rnd_data();
    pixel = byte'($urandom);
    for (int k = 0; k < 32; k++) begin
      w[k] = byte'($urandom);
      b[k] = byte'($urandom);
    end
    for (int j = 0; j < 10; j++)
      sc[j] = ($urandom % 3 == 0) ?
              20'(int'($urandom_range(0, 4)) - 2) : 20'($urandom);
  endtask

  task automatic set_l1(int mode, int i);
    rnd_data();
    init  = ($urandom % 16 == 0);
    start = 1'($urandom);
    case (mode)
      1: if (i == 0) begin
        init = 1'b1; b[0] = 8'sd2; pixel = 8'sd3; w[0] = 8'sd4;
      end
      2: if (i == 0) begin
        init = 1'b1; b[0] = byte'(-5); pixel = 8'sd0;
      end else begin
        init  = 1'b0;
        pixel = 8'sd127;
        w[0]  = (i <= 3) ? byte'(-128) : 8'sd127;
      end
      3: begin
        init = 1'b0;
        pixel = 8'sd127;
        for (int k = 0; k < 32; k++) w[k] = 8'sd127;
      end
      default: ;
    endcase
  endtask

  task automatic run(int mode, int abort_row);
    rnd_data(); start = 1'b1; init = 1'b0; step();
    rnd_data(); start = 1'b0; init = 1'b1; step();
    for (int i = 0; i < 784; i++) begin
      if (i == abort_row) begin
        rnd_data(); rst = 1'b1; start = 1'b0; step();
        rst = 1'b0; step();
        return;
      end
      set_l1(mode, i);
      step();
    end
    for (int n = 0; n < 40 && m_t >= 0; n++) begin
      rnd_data();
      init  = ($urandom % 8 == 0);
      start = (m_t < 819) ? 1'($urandom) : 1'b0;
      step();
    end
    start = 1'b0; init = 1'b0;
    repeat (3) begin rnd_data(); step(); end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({bus.busy, bus.done, bus.layer_sel, bus.load_img,
             bus.comp_l1, bus.apply_relu, bus.comp_l2,
             bus.find_max, bus.mac_en_l1, bus.mac_clr_l1,
             bus.mac_en_l2, bus.mac_clr_l2} !== e.ctl) begin
          errors++;
          $display("FAIL ctl @%0t got %b exp %b", $time,
            {bus.busy, bus.done, bus.layer_sel, bus.load_img,
             bus.comp_l1, bus.apply_relu, bus.comp_l2,
             bus.find_max, bus.mac_en_l1, bus.mac_clr_l1,
             bus.mac_en_l2, bus.mac_clr_l2}, e.ctl);
        end
        checks++;
        if (bus.row_idx !== e.row) begin
          errors++;
          $display("FAIL row_idx @%0t got %0d exp %0d",
                   $time, bus.row_idx, e.row);
        end
        checks++;
        if (bus.cycle_cnt !== e.cyc) begin
          errors++;
          $display("FAIL cycle_cnt @%0t got %0d exp %0d",
                   $time, bus.cycle_cnt, e.cyc);
        end
        checks++;
        if (bus.l1_acc_packed !== e.acc) begin
          errors++;
          for (int k = 0; k < 32; k++) begin
            if (bus.l1_acc_packed[20*k +: 20] !== e.acc[20*k +: 20]) begin
              $display("FAIL acc lane %0d @%0t got %0d exp %0d", k,
                       $time, $signed(bus.l1_acc_packed[20*k +: 20]),
                       $signed(e.acc[20*k +: 20]));
              break;
            end
          end
        end
        checks++;
        if (bus.max_idx !== e.mx) begin
          errors++;
          $display("FAIL max_idx @%0t got %0d exp %0d",
                   $time, bus.max_idx, e.mx);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 32; k++) macc[k] = '0;
    rst = 1'b1; start = 1'b0; init = 1'b0;
    rnd_data();
    @(posedge clk); #1;
    step(); step();
    rst = 1'b0;
    rnd_data(); step();
    for (int j = 0; j < 10; j++) sc[j] = 20'(-100);
    sc[0] = 20'(-7); sc[1] = 20'sd3; sc[2] = 20'sd3; sc[3] = 20'(-1);
    step();
    for (int j = 0; j < 10; j++) sc[j] = 20'sh80000;
    step();
    rnd_data(); sc[9] = 20'sh7ffff;
    step();
    rnd_data(); init = 1'b1; b[0] = byte'(-5);
    step();
    init = 1'b0;
    repeat (2) begin rnd_data(); step(); end
    run(1, -1);
    run(2, -1);
    run(0, 400);
    run(3, -1);
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
